aes_key_schedule: RTL and testbench

AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

---
 rtl/aes_key_schedule.sv | 211 +++++++++++++++++++++
 tb/tb_aes_key_schedule.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule.sv
// AES-128/192/256 key expansion: one FIPS-197 word per cycle into a 60-word store, with a combinational round-key read port.
// Optional synchronous key wipe: define AES_KEY_SCHED_ZEROIZE_EN to add the zeroize input.
//
// state  | meaning
// IDLE   | no key held (after reset or zeroize)
// EXPAND | generating w[Nk .. 4*(Nr+1)-1], one word per clock
// DONE   | full round-key set held, read port valid
module aes_key_schedule (
    input  logic         clk,
    input  logic         reset,
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    input  logic         zeroize,
`endif
    input  logic         key_load,
    input  logic [1:0]   key_len,
    input  logic [255:0] cipher_key,
    output logic         busy,
    output logic         keys_ready,
    input  logic [3:0]   subkey_addr,
    output logic [127:0] subkey,
    output logic         subkey_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Forward S-box, byte 0x00 in the top 8 bits.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] a);
        return SBOX_TABLE[{~a, 3'b111} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    state_t       state;
    state_t       state_next;
    logic [31:0]  w [0:59];
    logic [5:0]   word_cnt;
    logic [2:0]   phase;
    logic [7:0]   rcon;
    logic [1:0]   key_len_q;

    logic [5:0]   nk_q;
    logic [2:0]   phase_last;
    logic [3:0]   nr_q;
    logic [5:0]   last_idx;

    logic         zero_req;
    logic         accept;
    logic [5:0]   idx_prev;
    logic [5:0]   idx_back;
    logic [31:0]  temp;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;
    logic [31:0]  new_word;
    logic [5:0]   rd_base;

`ifdef AES_KEY_SCHED_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    always_comb begin
        nk_q       = 6'd4;
        phase_last = 3'd3;
        nr_q       = 4'd10;
        last_idx   = 6'd43;
        case (key_len_q)
            2'b10: begin
                nk_q       = 6'd6;
                phase_last = 3'd5;
                nr_q       = 4'd12;
                last_idx   = 6'd51;
            end
            2'b11: begin
                nk_q       = 6'd8;
                phase_last = 3'd7;
                nr_q       = 4'd14;
                last_idx   = 6'd59;
            end
            default: ;
        endcase
    end

    // Loads in EXPAND are dropped so a running expansion can never be corrupted.
    assign accept = key_load && (key_len != 2'b00) && (state != EXPAND) && !zero_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept)
                    state_next = EXPAND;
            end
            EXPAND: begin
                if (word_cnt == last_idx)
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
        if (zero_req)
            state_next = IDLE;
    end

    assign busy       = (state == EXPAND);
    assign keys_ready = (state == DONE);

    // phase tracks i mod Nk without a divider; phase 0 is the RotWord/Rcon word.
    assign idx_prev = word_cnt - 6'd1;
    assign idx_back = word_cnt - nk_q;
    assign temp     = w[idx_prev];
    assign sub_in   = (phase == 3'd0) ? {temp[23:0], temp[31:24]} : temp;
    assign sub_out  = sub_word(sub_in);

    always_comb begin
        new_word = w[idx_back] ^ temp;
        if (phase == 3'd0)
            new_word = w[idx_back] ^ sub_out ^ {rcon, 24'h000000};
        else if ((key_len_q == 2'b11) && (phase == 3'd4))
            new_word = w[idx_back] ^ sub_out;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < 60; j++)
                w[j] <= '0;
            word_cnt  <= '0;
            phase     <= '0;
            rcon      <= 8'h01;
            key_len_q <= 2'b00;
        end else if (zero_req) begin
            for (int j = 0; j < 60; j++)
                w[j] <= '0;
            word_cnt  <= '0;
            phase     <= '0;
            rcon      <= 8'h01;
            key_len_q <= 2'b00;
        end else if (accept) begin
            for (int j = 0; j < 4; j++)
                w[j] <= cipher_key[255 - 32*j -: 32];
            if (key_len != 2'b01) begin
                w[4] <= cipher_key[127:96];
                w[5] <= cipher_key[95:64];
            end
            if (key_len == 2'b11) begin
                w[6] <= cipher_key[63:32];
                w[7] <= cipher_key[31:0];
            end
            case (key_len)
                2'b10:   word_cnt <= 6'd6;
                2'b11:   word_cnt <= 6'd8;
                default: word_cnt <= 6'd4;
            endcase
            phase     <= '0;
            rcon      <= 8'h01;
            key_len_q <= key_len;
        end else if (state == EXPAND) begin
            w[word_cnt] <= new_word;
            word_cnt    <= word_cnt + 6'd1;
            phase       <= (phase == phase_last) ? 3'd0 : phase + 3'd1;
            if (phase == 3'd0)
                rcon <= xtime(rcon);
        end
    end

    assign rd_base = {subkey_addr, 2'b00};

    always_comb begin
        subkey = '0;
        if (subkey_addr <= 4'd14)
            subkey = {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]};
    end

    assign subkey_valid = keys_ready && (subkey_addr <= nr_q);

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule: FIPS-197 vector table plus ignored-load, re-key, reset and zeroize sequences.
module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_load;
    logic [1:0]   key_len;
    logic [255:0] cipher_key;
    logic         busy;
    logic         keys_ready;
    logic [3:0]   subkey_addr;
    logic [127:0] subkey;
    logic         subkey_valid;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    logic         zeroize;
`endif

    aes_key_schedule dut (
        .clk          (clk),
        .reset        (reset),
`ifdef AES_KEY_SCHED_ZEROIZE_EN
        .zeroize      (zeroize),
`endif
        .key_load     (key_load),
        .key_len      (key_len),
        .cipher_key   (cipher_key),
        .busy         (busy),
        .keys_ready   (keys_ready),
        .subkey_addr  (subkey_addr),
        .subkey       (subkey),
        .subkey_valid (subkey_valid)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    typedef struct {
        logic [1:0]   len;
        logic [255:0] key;
        logic [3:0]   addr;
        logic [127:0] exp_key;
        logic         exp_valid;
        int           exp_lat;
    } vec_t;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [1:0] len, input logic [255:0] key);
        key_len    = len;
        cipher_key = key;
        key_load   = 1'b1;
        tick();
        key_load   = 1'b0;
    endtask

    task automatic wait_ready(inout int cyc);
        while (!keys_ready && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t         vecs [13];
        logic [1:0]   last_len;
        logic [255:0] last_key;
        int           lat;

        vecs[0]  = '{2'b01, K128, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, 40};
        vecs[1]  = '{2'b01, K128, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b1, 40};
        vecs[2]  = '{2'b01, K128, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1, 40};
        vecs[3]  = '{2'b01, K128, 4'd11, 128'h0,                                1'b0, 40};
        vecs[4]  = '{2'b10, K192, 4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5, 1'b1, 46};
        vecs[5]  = '{2'b10, K192, 4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5, 1'b1, 46};
        vecs[6]  = '{2'b10, K192, 4'd12, 128'he98ba06f448c773c8ecc720401002202, 1'b1, 46};
        vecs[7]  = '{2'b10, K192, 4'd13, 128'h0,                                1'b0, 46};
        vecs[8]  = '{2'b11, K256, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781, 1'b1, 52};
        vecs[9]  = '{2'b11, K256, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4, 1'b1, 52};
        vecs[10] = '{2'b11, K256, 4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde, 1'b1, 52};
        vecs[11] = '{2'b11, K256, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b1, 52};
        vecs[12] = '{2'b11, K256, 4'd15, 128'h0,                                1'b0, 52};

        reset       = 1'b1;
        key_load    = 1'b0;
        key_len     = 2'b00;
        cipher_key  = '0;
        subkey_addr = 4'd0;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
        zeroize     = 1'b0;
`endif
        #12;
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_keys_ready", 128'(keys_ready), 128'd0);
        check("reset_subkey_valid", 128'(subkey_valid), 128'd0);
        check("reset_store", subkey, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        last_len = 2'b00;
        last_key = '0;
        for (int v = 0; v < 13; v++) begin
            if (vecs[v].len != last_len || vecs[v].key != last_key) begin
                load_key(vecs[v].len, vecs[v].key);
                check($sformatf("v%0d_busy_after_load", v), 128'(busy), 128'd1);
                lat = 0;
                wait_ready(lat);
                check($sformatf("v%0d_latency", v), 128'(lat), 128'(vecs[v].exp_lat));
                last_len = vecs[v].len;
                last_key = vecs[v].key;
            end
            subkey_addr = vecs[v].addr;
            #1;
            check($sformatf("v%0d_valid", v), 128'(subkey_valid), 128'(vecs[v].exp_valid));
            if (vecs[v].exp_valid)
                check($sformatf("v%0d_subkey", v), subkey, vecs[v].exp_key);
        end

        // Invalid key length in DONE leaves the held set untouched.
        key_len  = 2'b00;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        check("len00_in_done_ready", 128'(keys_ready), 128'd1);
        check("len00_in_done_busy", 128'(busy), 128'd0);

        // Re-key from DONE drops validity at once; loads during EXPAND are ignored.
        subkey_addr = 4'd0;
        load_key(2'b01, K128);
        check("rekey_valid_drop", 128'(subkey_valid), 128'd0);
        check("rekey_busy", 128'(busy), 128'd1);
        lat = 0;
        repeat (5) begin
            tick();
            lat++;
        end
        key_len    = 2'b11;
        cipher_key = K256;
        key_load   = 1'b1;
        tick();
        lat++;
        key_len    = 2'b00;
        tick();
        lat++;
        key_load   = 1'b0;
        wait_ready(lat);
        check("ignored_load_latency", 128'(lat), 128'd40);
        subkey_addr = 4'd10;
        #1;
        check("ignored_load_subkey10", subkey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        subkey_addr = 4'd11;
        #1;
        check("ignored_load_addr11_valid", 128'(subkey_valid), 128'd0);

        // Reset in the middle of an expansion, then a clean restart.
        subkey_addr = 4'd0;
        load_key(2'b10, K192);
        repeat (20) tick();
        #2;
        reset = 1'b1;
        #1;
        check("midreset_busy", 128'(busy), 128'd0);
        check("midreset_keys_ready", 128'(keys_ready), 128'd0);
        check("midreset_subkey_valid", 128'(subkey_valid), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        key_len  = 2'b00;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        check("len00_in_idle_busy", 128'(busy), 128'd0);
        load_key(2'b11, K256);
        lat = 0;
        wait_ready(lat);
        check("restart_latency", 128'(lat), 128'd52);
        subkey_addr = 4'd14;
        #1;
        check("restart_subkey14", subkey, 128'hfe4890d1e6188d0b046df344706c631e);
        check("restart_valid14", 128'(subkey_valid), 128'd1);

`ifdef AES_KEY_SCHED_ZEROIZE_EN
        zeroize    = 1'b1;
        key_len    = 2'b01;
        cipher_key = K128;
        key_load   = 1'b1;
        tick();
        zeroize    = 1'b0;
        key_load   = 1'b0;
        subkey_addr = 4'd0;
        #1;
        check("zeroize_busy", 128'(busy), 128'd0);
        check("zeroize_keys_ready", 128'(keys_ready), 128'd0);
        check("zeroize_valid", 128'(subkey_valid), 128'd0);
        check("zeroize_store0", subkey, 128'd0);
        subkey_addr = 4'd14;
        #1;
        check("zeroize_store14", subkey, 128'd0);
        tick();
        check("zeroize_no_expand", 128'(busy), 128'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
